spi_regfile_subnode: RTL

SPI_REGFILE_SUBNODE -- requirements
Module: spi_regfile_subnode

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_regfile_subnode.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI register-file subnode.
package spi_pkg;

  localparam int CMD_W  = 8;
  localparam int RW_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with rise/fall detect
// taken between the synchronised level and one extra history flop.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_regfile_subnode.sv
// SPI mode-0 target that turns framed commands into single-clk write strobes
// and serialises an external register file for reads, with address bursts.
module spi_regfile_subnode
  import spi_pkg::*;
#(
  parameter  int REG_W    = 64,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              csb,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [REG_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [REG_W-1:0]  rd_data,
  input  logic              err_clr,
  output logic              err_flag,
  output logic              busy
);

  localparam int CNT_W = $clog2(REG_W);

  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_csb_lvl, w_csb_rise, w_csb_fall;
  logic w_mosi;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sck),
    .o_level (w_sck_lvl),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_csb_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (csb),
    .o_level (w_csb_lvl),
    .o_rise  (w_csb_rise),
    .o_fall  (w_csb_fall)
  );

  logic r_mosi_s1;
  logic r_mosi_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_mosi = r_mosi_s2;

  // A frame may only start once the synchronisers hold real samples and the
  // bus has been seen idle; this keeps a reset released mid-frame in IDLE.
  logic [1:0] r_sync_vld;
  logic       r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (r_sync_vld[1] && w_csb_lvl && !w_sck_lvl)
        r_armed <= 1'b1;
    end
  end

  spi_state_e         r_state;
  logic [CMD_W-2:0]   r_cmd;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic               r_rd_mode;
  logic               r_load;
  logic [REG_W-1:0]   r_shift;
  logic               r_miso;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [REG_W-1:0]   r_wr_data;
  logic               r_err;

  logic [CMD_W-1:0]   w_cmd_full;
  logic               w_addr_ok;
  logic [REG_W-1:0]   w_word;
  logic [ADDR_W-1:0]  w_next_addr;

  assign w_cmd_full  = {r_cmd, w_mosi};
  assign w_addr_ok   = (int'(w_cmd_full[RW_BIT-1:0]) < NUM_REGS);
  assign w_word      = {r_shift[REG_W-2:0], w_mosi};
  assign w_next_addr = (r_cur_addr == ADDR_W'(NUM_REGS - 1)) ? '0
                                                             : r_cur_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_cnt      <= '0;
      r_cur_addr <= '0;
      r_rd_mode  <= 1'b0;
      r_load     <= 1'b0;
      r_shift    <= '0;
      r_miso     <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_load  <= 1'b0;
      // Clear first so that a same-cycle error set below takes priority.
      if (err_clr)
        r_err <= 1'b0;

      if (w_csb_rise) begin
        r_state <= ST_IDLE;
        r_miso  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_csb_fall && r_armed) begin
              r_state <= ST_CMD;
              r_cnt   <= '0;
            end
          end

          ST_CMD: begin
            if (w_sck_rise) begin
              if (r_cnt == CNT_W'(CMD_W - 1)) begin
                if (!w_addr_ok) begin
                  r_state <= ST_ERR;
                  r_err   <= 1'b1;
                end else begin
                  r_state    <= ST_DATA;
                  r_cur_addr <= w_cmd_full[ADDR_W-1:0];
                  r_rd_mode  <= w_cmd_full[RW_BIT];
                  r_load     <= w_cmd_full[RW_BIT];
                  r_cnt      <= CNT_W'(REG_W - 1);
                end
              end else begin
                r_cmd <= w_cmd_full[CMD_W-2:0];
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end

          ST_DATA: begin
            // rd_addr follows r_cur_addr, so rd_data is valid the clk after
            // the address moved.
            if (r_load)
              r_shift <= rd_data;
            if (w_sck_rise) begin
              if (!r_rd_mode)
                r_shift <= w_word;
              if (r_cnt == '0) begin
                if (!r_rd_mode) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_cur_addr;
                  r_wr_data <= w_word;
                end else begin
                  r_load <= 1'b1;
                end
                r_cur_addr <= w_next_addr;
                r_cnt      <= CNT_W'(REG_W - 1);
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
            if (w_sck_fall && r_rd_mode && !r_load) begin
              r_miso  <= r_shift[REG_W-1];
              r_shift <= {r_shift[REG_W-2:0], 1'b0};
            end
          end

          ST_ERR: begin
          end
        endcase
      end
    end
  end

  assign miso     = r_miso;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_addr  = r_cur_addr;
  assign err_flag = r_err;
  assign busy     = ~w_csb_lvl;

endmodule
